// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART command-frame controller.
//   state_t     : frame-parser FSM states
//   SOF_DEFAULT : default start-of-frame byte value
//   in_frame()  : true while the FSM is collecting the body of a frame
//                 (the states in which the inter-byte timeout is armed)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_HI  = 3'd2,
        GET_LO  = 3'd3,
        GET_CHK = 3'd4,
        HOLD    = 3'd5
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    function automatic logic in_frame(input state_t s);
        return (s == GET_CMD) || (s == GET_HI) || (s == GET_LO) || (s == GET_CHK);
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// ---------------------------------------------------------------------------
// uart_frame_timer
// 16-bit inter-byte timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable
//   expired    : high while enabled and the count sits at TO_CYC-1
// ---------------------------------------------------------------------------
module uart_frame_timer #(
    parameter int unsigned TO_CYC = 52080
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(TO_CYC - 1);

    logic [15:0] count;

    // Count parks at LAST so a stalled frame cannot wrap and re-arm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (clr) begin
            count <= 16'h0000;
        end else if (en && (count != LAST)) begin
            count <= count + 16'h0001;
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
// Parses SOF, CMD, DATA_HI, DATA_LO, CHK frames arriving byte-by-byte from a
// UART receiver and presents the decoded command to a consumer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   rdy, rx_data : byte-ready flag and received byte from the receiver
//   clr_rdy      : registered one-cycle acknowledge back to the receiver
//   clr_cmd_rdy  : consumer acknowledge of the presented command
//   cmd_rdy      : cmd/data hold a valid frame
//   cmd, data    : command byte and {DATA_HI, DATA_LO} of the last good frame
//   frame_err    : one-cycle pulse on checksum failure or inter-byte timeout
//   ovr          : sticky overrun, set when a byte is dropped while holding
// ---------------------------------------------------------------------------
module uart_cmd_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned TO_CYC = 52080,
    parameter logic [7:0]  SOF    = uart_pkg::SOF_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rdy,
    input  logic        clr_cmd_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        frame_err,
    output logic        ovr
);

    state_t      state, state_next;
    logic        accept;
    logic        expired;

    logic [7:0]  sh_cmd, sh_hi, sh_lo, sum;
    logic [7:0]  sh_cmd_next, sh_hi_next, sh_lo_next, sum_next;
    logic        cmd_rdy_next, err_next, ovr_next;
    logic [7:0]  cmd_next;
    logic [15:0] data_next;

    // clr_rdy is high in the cycle after an accept, masking the still-high
    // rdy so the same byte is never consumed twice.
    assign accept = rdy && !clr_rdy;

    uart_frame_timer #(
        .TO_CYC (TO_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (accept),
        .en      (in_frame(state)),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_rdy   <= 1'b0;
            cmd_rdy   <= 1'b0;
            cmd       <= 8'h00;
            data      <= 16'h0000;
            frame_err <= 1'b0;
            ovr       <= 1'b0;
            sh_cmd    <= 8'h00;
            sh_hi     <= 8'h00;
            sh_lo     <= 8'h00;
            sum       <= 8'h00;
        end else begin
            state     <= state_next;
            clr_rdy   <= accept;
            cmd_rdy   <= cmd_rdy_next;
            cmd       <= cmd_next;
            data      <= data_next;
            frame_err <= err_next;
            ovr       <= ovr_next;
            sh_cmd    <= sh_cmd_next;
            sh_hi     <= sh_hi_next;
            sh_lo     <= sh_lo_next;
            sum       <= sum_next;
        end
    end

    always_comb begin
        state_next   = state;
        cmd_rdy_next = cmd_rdy;
        cmd_next     = cmd;
        data_next    = data;
        err_next     = 1'b0;
        ovr_next     = ovr;
        sh_cmd_next  = sh_cmd;
        sh_hi_next   = sh_hi;
        sh_lo_next   = sh_lo;
        sum_next     = sum;

        // The consumer acknowledge always clears the overrun, in any state.
        if (clr_cmd_rdy) begin
            ovr_next = 1'b0;
        end

        // In the body states an accepted byte beats a coincident expiry.
        case (state)
            IDLE: begin
                sum_next = 8'h00;
                if (accept && (rx_data == SOF)) begin
                    state_next = GET_CMD;
                end
            end

            GET_CMD: begin
                if (accept) begin
                    sh_cmd_next = rx_data;
                    sum_next    = sum + rx_data;
                    state_next  = GET_HI;
                end else if (expired) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end

            GET_HI: begin
                if (accept) begin
                    sh_hi_next = rx_data;
                    sum_next   = sum + rx_data;
                    state_next = GET_LO;
                end else if (expired) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end

            GET_LO: begin
                if (accept) begin
                    sh_lo_next = rx_data;
                    sum_next   = sum + rx_data;
                    state_next = GET_CHK;
                end else if (expired) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end

            GET_CHK: begin
                if (accept) begin
                    if (rx_data == sum) begin
                        cmd_next     = sh_cmd;
                        data_next    = {sh_hi, sh_lo};
                        cmd_rdy_next = 1'b1;
                        state_next   = HOLD;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end else if (expired) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end

            HOLD: begin
                // Cleared here so a SOF taken on the release edge starts a
                // fresh checksum.
                sum_next = 8'h00;
                if (clr_cmd_rdy) begin
                    cmd_rdy_next = 1'b0;
                    // A byte arriving with the release is judged as if idle.
                    if (accept && (rx_data == SOF)) begin
                        state_next = GET_CMD;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (accept) begin
                    ovr_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;

    localparam int unsigned TO = 64;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic [7:0]  rx_data;
    logic        clr_rdy;
    logic        clr_cmd_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        frame_err;
    logic        ovr;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int err_base;
    logic acc_cmd_rdy;
    logic acc_err;

    uart_cmd_ctrl #(
        .TO_CYC (TO),
        .SOF    (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .rx_data     (rx_data),
        .clr_rdy     (clr_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .frame_err   (frame_err),
        .ovr         (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Receiver model: rdy stays up until clr_rdy has been seen, so every byte
    // is held two cycles and the acknowledge is checked to be one cycle wide.
    task automatic send_byte(input logic [7:0] b);
        rdy     = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        check("clr_rdy_hi", clr_rdy, 1'b1);
        acc_cmd_rdy = cmd_rdy;
        acc_err     = frame_err;
        @(posedge clk); #1;
        check("clr_rdy_lo", clr_rdy, 1'b0);
        rdy = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
    endtask

    task automatic release_cmd();
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clr_rdy"},   clr_rdy,   1'b0);
        check({tag, "_cmd_rdy"},   cmd_rdy,   1'b0);
        check({tag, "_cmd"},       cmd,       8'h00);
        check({tag, "_data"},      data,      16'h0000);
        check({tag, "_frame_err"}, frame_err, 1'b0);
        check({tag, "_ovr"},       ovr,       1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        rdy         = 1'b0;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b0;
        acc_cmd_rdy = 1'b0;
        acc_err     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Good frame
        err_base = err_cnt;
        send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C);
        check("good_cmd_rdy_lat", acc_cmd_rdy, 1'b1);
        check("good_cmd", cmd, 8'h12);
        check("good_data", data, 16'h3456);
        check("good_no_err", err_cnt - err_base, 0);
        release_cmd();
        check("good_release", cmd_rdy, 1'b0);
        check("good_cmd_kept", cmd, 8'h12);

        // Bad checksum
        err_base = err_cnt;
        send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9D);
        check("badchk_err_pulse", acc_err, 1'b1);
        check("badchk_err_once", frame_err, 1'b0);
        check("badchk_err_cnt", err_cnt - err_base, 1);
        check("badchk_cmd_rdy", cmd_rdy, 1'b0);
        check("badchk_data_kept", data, 16'h3456);

        // Leading junk, then a frame
        err_base = err_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'hA5, 8'h01, 8'h00, 8'h02, 8'h03);
        check("junk_cmd_rdy", cmd_rdy, 1'b1);
        check("junk_cmd", cmd, 8'h01);
        check("junk_data", data, 16'h0002);
        check("junk_no_err", err_cnt - err_base, 0);
        release_cmd();

        // Inter-byte timeout
        err_base = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h12);
        repeat (TO - 2) @(posedge clk);
        #1;
        check("to_not_early", frame_err, 1'b0);
        check("to_not_early_cnt", err_cnt - err_base, 0);
        @(posedge clk); #1;
        check("to_pulse", frame_err, 1'b1);
        @(posedge clk); #1;
        check("to_pulse_single", frame_err, 1'b0);
        check("to_err_cnt", err_cnt - err_base, 1);
        check("to_cmd_rdy", cmd_rdy, 1'b0);
        err_base = err_cnt;
        send_frame(8'hA5, 8'h01, 8'h00, 8'h00, 8'h01);
        check("after_to_cmd_rdy", cmd_rdy, 1'b1);
        check("after_to_cmd", cmd, 8'h01);
        check("after_to_data", data, 16'h0000);
        check("after_to_no_err", err_cnt - err_base, 0);
        release_cmd();

        // Byte accepted exactly on the expiry cycle wins
        err_base = err_cnt;
        send_byte(8'hA5);
        repeat (TO - 2) @(posedge clk);
        #1;
        send_byte(8'h42);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h43);
        check("edge_no_err", err_cnt - err_base, 0);
        check("edge_cmd_rdy", cmd_rdy, 1'b1);
        check("edge_cmd", cmd, 8'h42);
        check("edge_data", data, 16'h0001);

        // Overrun while holding
        check("ovr_before", ovr, 1'b0);
        send_byte(8'h77);
        check("ovr_set", ovr, 1'b1);
        check("ovr_cmd_kept", cmd, 8'h42);
        check("ovr_data_kept", data, 16'h0001);
        check("ovr_cmd_rdy_kept", cmd_rdy, 1'b1);
        release_cmd();
        check("ovr_rel_cmd_rdy", cmd_rdy, 1'b0);
        check("ovr_rel_ovr", ovr, 1'b0);

        // Release coinciding with a SOF byte
        send_frame(8'hA5, 8'h10, 8'h20, 8'h30, 8'h60);
        check("co_cmd", cmd, 8'h10);
        check("co_data", data, 16'h2030);
        rdy         = 1'b1;
        rx_data     = 8'hA5;
        clr_cmd_rdy = 1'b1;
        @(posedge clk); #1;
        clr_cmd_rdy = 1'b0;
        check("co_clr_rdy", clr_rdy, 1'b1);
        check("co_cmd_rdy", cmd_rdy, 1'b0);
        check("co_ovr", ovr, 1'b0);
        @(posedge clk); #1;
        rdy = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h66);
        check("co_next_cmd_rdy", acc_cmd_rdy, 1'b1);
        check("co_next_cmd", cmd, 8'h11);
        check("co_next_data", data, 16'h2233);
        release_cmd();

        // Reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h12);
        send_byte(8'h34);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        err_base = err_cnt;
        send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C);
        check("postrst_cmd_rdy", acc_cmd_rdy, 1'b1);
        check("postrst_cmd", cmd, 8'h12);
        check("postrst_data", data, 16'h3456);
        check("postrst_no_err", err_cnt - err_base, 0);
        release_cmd();
        check("postrst_release", cmd_rdy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TO_CYC, default 52080, SHALL set the inter-byte timeout in clk cycles (about 2 byte times at 2604 clk/bit).
REQ-002 Parameter SOF, default 8'hA5, SHALL be the start-of-frame byte value.
REQ-003 clk  input  1  SHALL be the clock; all state updates occur on posedge clk.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 rdy  input  1  SHALL be the byte-ready flag from the UART receiver.
REQ-006 rx_data  input  8  SHALL be the received byte, valid only while rdy=1.
REQ-007 clr_rdy  output  1  SHALL be the registered one-cycle acknowledge to the receiver.
REQ-008 clr_cmd_rdy  input  1  SHALL be the consumer acknowledge of a completed command.
REQ-009 cmd_rdy  output  1  SHALL flag that cmd/data hold a valid frame.
REQ-010 cmd  output  8  SHALL be the command byte of the last good frame.
REQ-011 data  output  16  SHALL be {DATA_HI, DATA_LO} of the last good frame.
REQ-012 frame_err  output  1  SHALL pulse one cycle on checksum failure or timeout.
REQ-013 ovr  output  1  SHALL be a sticky overrun flag, set when a byte is dropped in HOLD.

Function
REQ-014 Frame format SHALL be SOF, CMD, DATA_HI, DATA_LO, CHK, where CHK = (CMD+DATA_HI+DATA_LO) mod 256.
REQ-015 A byte SHALL be accepted in a cycle where rdy=1 and clr_rdy=0. clr_rdy SHALL be 1 in the following cycle only, so no byte is consumed twice.
REQ-016 The FSM SHALL have states IDLE, GET_CMD, GET_HI, GET_LO, GET_CHK and HOLD.
REQ-017 In IDLE, an accepted byte equal to SOF SHALL move the FSM to GET_CMD. Any other byte SHALL be consumed and discarded.
REQ-018 GET_CMD, GET_HI and GET_LO SHALL store the accepted byte in a shadow register and advance to the next state.
REQ-019 In GET_CHK, a matching CHK SHALL load cmd/data from the shadow registers, set cmd_rdy on that edge and move to HOLD. The total latency is 1 clk after CHK acceptance.
REQ-020 In GET_CHK, a mismatching CHK SHALL pulse frame_err, leave cmd/data/cmd_rdy unchanged and return to IDLE.
REQ-021 A 16-bit timer SHALL clear on entry to GET_CMD and on every accepted byte, and SHALL count in GET_CMD through GET_CHK.
REQ-022 When the timer reaches TO_CYC-1 with no byte accepted, the block SHALL pulse frame_err and return to IDLE.
REQ-023 A byte accepted in the same cycle that the timer expires SHALL win: no error, and the timer clears.
REQ-024 cmd_rdy, cmd and data SHALL hold stable in HOLD until clr_cmd_rdy=1. cmd_rdy SHALL then clear on that edge and the FSM SHALL go to IDLE.
REQ-025 In HOLD, a byte accepted without clr_cmd_rdy SHALL be consumed (clr_rdy pulses), dropped, and SHALL set ovr.
REQ-026 ovr SHALL clear only on clr_cmd_rdy or reset.
REQ-027 If clr_cmd_rdy and an accepted byte coincide in HOLD, the byte SHALL be evaluated under the IDLE rules: SOF goes to GET_CMD, and ovr is not set.
REQ-028 clr_cmd_rdy outside HOLD SHALL clear ovr only and have no other effect.
REQ-029 frame_err SHALL be a single-cycle pulse and never asserted two consecutive cycles.

Reset
REQ-030 On rst_n=0, the block SHALL set: state=IDLE, clr_rdy=0, cmd_rdy=0, cmd=8'h00, data=16'h0000, frame_err=0, ovr=0, timer=0, shadow registers=0.
REQ-031 Reset mid-frame SHALL discard the partial frame. After release, the first accepted byte SHALL be judged under the IDLE rules.

Structure
REQ-032 The state enum and the default SOF constant SHALL reside in shared package uart_pkg.
REQ-033 The timeout counter SHALL be one sub-module, uart_frame_timer, with inputs clr and en, parameter TO_CYC, and output expired.
REQ-034 The checksum SHALL be accumulated incrementally as an 8-bit sum, cleared in IDLE.

Verification
REQ-035 Bytes A5,12,34,56,9C -> cmd=12, data=3456 and cmd_rdy=1 one clk after the 9C byte is accepted; frame_err=0.
REQ-036 Bytes A5,12,34,56,9D -> one frame_err pulse, cmd_rdy stays 0, FSM in IDLE.
REQ-037 Bytes 00,FF, then A5,01,00,02,03 -> the leading bytes are dropped silently; then cmd=01, data=0002.
REQ-038 Bytes A5,12 then no rdy for TO_CYC cycles -> one frame_err pulse. Next A5,01,00,00,01 decodes correctly.
REQ-039 A good frame with clr_cmd_rdy held 0, then byte 77 -> ovr=1, cmd/data unchanged. Then clr_cmd_rdy=1 -> cmd_rdy=0 and ovr=0.
REQ-040 rst_n asserted after A5,12,34 -> all outputs at reset values. Next A5,12,34,56,9C decodes normally; rdy is held >=2 cycles each time, and clr_rdy is checked to be exactly 1 cycle per byte.
